// File: rtl/ft245_tx_arbiter.sv
// rtl/ft245_tx_arbiter.sv - round-robin packet arbiter feeding the FT245 TX channel
// Locks a grant per packet, optionally prefixes a source-ID header, aborts stalled packets.
module ft245_tx_arbiter #(
  parameter int         N              = 4,
  parameter bit         HEADER_EN      = 1'b1,
  parameter logic [3:0] HEADER_TAG     = 4'hA,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [8*N-1:0] req_data_i,
  input  logic [N-1:0]   req_rdy_i,
  input  logic [N-1:0]   req_last_i,
  output logic [N-1:0]   req_ack_o,
  output logic [7:0]     tx_data_si,
  output logic           tx_rdy_si,
  input  logic           tx_ack_si,
  output logic [N-1:0]   grant_o,
  output logic           busy_o,
  output logic           timeout_err_o
);

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DRAIN} state_t;

  state_t      state;
  logic [3:0]  gidx;
  logic [3:0]  ptr;
  logic        hold_valid;
  logic [7:0]  hold_data;
  logic [15:0] tmo_cnt;

  logic        found;
  logic [3:0]  pick;
  logic [N-1:0] pick_oh;
  logic        rdy_g;
  logic        last_g;
  logic [7:0]  data_g;
  logic        slot_free;
  logic        load_data;
  logic        tmo_hit;
  logic [3:0]  next_ptr;
  logic [7:0]  hdr_byte;

  // Select the granted source's request lines.
  always_comb begin
    rdy_g  = 1'b0;
    last_g = 1'b0;
    data_g = 8'h00;
    for (int k = 0; k < N; k++) begin
      if (gidx == 4'(k)) begin
        rdy_g  = req_rdy_i[k];
        last_g = req_last_i[k];
        data_g = req_data_i[8*k +: 8];
      end
    end
  end

  // Round robin: the requester closest at or above the pointer (with wrap) wins.
  always_comb begin
    int best;
    int d;
    best  = N;
    d     = 0;
    found = 1'b0;
    pick  = 4'd0;
    for (int k = 0; k < N; k++) begin
      d = (k >= int'(ptr)) ? (k - int'(ptr)) : (k + N - int'(ptr));
      if (req_rdy_i[k] && (d < best)) begin
        best  = d;
        pick  = 4'(k);
        found = 1'b1;
      end
    end
  end

  assign pick_oh   = {{(N-1){1'b0}}, 1'b1} << pick;
  assign slot_free = !hold_valid || tx_ack_si;
  assign load_data = (state == DATA) && slot_free && rdy_g;
  assign tmo_hit   = (TMO != 16'd0) && (state == DATA) && slot_free && !rdy_g &&
                     (tmo_cnt == TMO - 16'd1);
  assign next_ptr  = (gidx == 4'(N-1)) ? 4'd0 : gidx + 4'd1;
  assign hdr_byte  = {HEADER_TAG, gidx};

  assign req_ack_o  = load_data ? grant_o : '0;
  assign tx_rdy_si  = hold_valid;
  assign tx_data_si = hold_data;
  assign busy_o     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      gidx          <= 4'd0;
      ptr           <= 4'd0;
      hold_valid    <= 1'b0;
      hold_data     <= 8'h00;
      tmo_cnt       <= 16'd0;
      grant_o       <= '0;
      timeout_err_o <= 1'b0;
    end else begin
      timeout_err_o <= 1'b0;

      // Load wins over drain so a byte can enter on the same edge the old one leaves.
      if (state == HDR && slot_free) begin
        hold_valid <= 1'b1;
        hold_data  <= hdr_byte;
      end else if (load_data) begin
        hold_valid <= 1'b1;
        hold_data  <= data_g;
      end else if (tx_ack_si) begin
        hold_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (found) begin
            gidx    <= pick;
            grant_o <= pick_oh;
            tmo_cnt <= 16'd0;
            state   <= HEADER_EN ? HDR : DATA;
          end
        end
        HDR: begin
          if (slot_free) begin
            tmo_cnt <= 16'd0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (load_data) begin
            tmo_cnt <= 16'd0;
            if (last_g) state <= DRAIN;
          end else if (tmo_hit) begin
            timeout_err_o <= 1'b1;
            state         <= DRAIN;
          end else if (slot_free && (tmo_cnt != 16'hFFFF)) begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        DRAIN: begin
          if (!hold_valid || tx_ack_si) begin
            grant_o <= '0;
            ptr     <= next_ptr;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// tb/tb_ft245_tx_arbiter.sv - scoreboard bench for ft245_tx_arbiter
module tb_ft245_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_rdy  = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ack;
  logic [7:0]     tx_data;
  logic           tx_rdy;
  logic           tx_ack = 1'b0;
  logic [N-1:0]   grant;
  logic           busy;
  logic           terr;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [7:0] sb[N][$];
  bit         sl[N][$];
  int         pos[N];
  int         gap[N];
  int         left[N];
  int         midx[N];
  logic [N-1:0] acked;

  always #5 clk = ~clk;

  ft245_tx_arbiter #(
    .N(N), .HEADER_EN(1'b1), .HEADER_TAG(4'hA), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_data_i(req_data), .req_rdy_i(req_rdy), .req_last_i(req_last),
    .req_ack_o(req_ack),
    .tx_data_si(tx_data), .tx_rdy_si(tx_rdy), .tx_ack_si(tx_ack),
    .grant_o(grant), .busy_o(busy), .timeout_err_o(terr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(name, busy, 0);
  endtask

  task automatic wait_ack(input int k, input string name);
    bit got;
    got = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (req_ack[k]) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, got, 1);
  endtask

  task automatic wait_tx_rdy(input string name);
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (tx_rdy) break;
    end
    chk(name, tx_rdy, 1);
  endtask

  initial begin
    int rp;
    int sel;
    int cyc;
    int npk;
    int len;
    bit lastb;

    fork
      forever begin
        @(negedge clk);
        if (rst && tx_rdy && tx_ack) begin
          if (exp_q.size() == 0) begin
            chk("tx_unexpected", {24'h0, tx_data}, 32'h100);
          end else begin
            mon_exp = exp_q.pop_front();
            chk("tx_byte", tx_data, mon_exp);
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_rdy", tx_rdy, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_terr", terr, 0);
    step();
    rst = 1'b1;

    // Random packets from every source; expected stream from a round-robin model
    for (int k = 0; k < N; k++) begin
      npk = $urandom_range(1, 3);
      left[k] = npk;
      midx[k] = 0;
      for (int p = 0; p < npk; p++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          sb[k].push_back(8'($urandom_range(0, 255)));
          sl[k].push_back(b == len - 1);
        end
      end
    end
    rp = 0;
    for (int guard = 0; guard < 64; guard++) begin
      sel = -1;
      for (int i = 0; i < N; i++)
        if (sel < 0 && left[(rp + i) % N] > 0) sel = (rp + i) % N;
      if (sel < 0) break;
      exp_q.push_back({4'hA, 4'(sel)});
      do begin
        exp_q.push_back(sb[sel][midx[sel]]);
        lastb = sl[sel][midx[sel]];
        midx[sel]++;
      end while (!lastb);
      left[sel]--;
      rp = (sel + 1) % N;
    end

    for (int k = 0; k < N; k++) begin
      pos[k] = 0;
      gap[k] = 0;
    end
    acked = '0;
    cyc = 0;
    while (cyc < 3000 && (exp_q.size() != 0 || busy)) begin
      step();
      for (int k = 0; k < N; k++) begin
        if (acked[k]) begin
          pos[k]++;
          gap[k] = (pos[k] < sb[k].size() && !sl[k][pos[k]-1]) ? $urandom_range(0, 3) : 0;
        end
        if (pos[k] < sb[k].size() && gap[k] == 0) begin
          req_rdy[k]         = 1'b1;
          req_data[8*k +: 8] = sb[k][pos[k]];
          req_last[k]        = sl[k][pos[k]];
        end else begin
          req_rdy[k]  = 1'b0;
          req_last[k] = 1'b0;
          if (gap[k] > 0) gap[k]--;
        end
      end
      tx_ack = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acked = req_ack;
      if (req_ack != '0) chk("ack_granted_only", req_ack & ~grant, 0);
      cyc++;
    end
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_grant_idle", grant, 0);
    step();
    req_rdy = '0;
    req_last = '0;
    tx_ack = 1'b0;
    wait_idle("rand_idle");

    // Back-pressure: header stuck in hold for 10 cycles
    step();
    req_rdy = 4'b0100;
    req_data[23:16] = 8'h11;
    req_last = '0;
    tx_ack = 1'b0;
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    wait_tx_rdy("bp_hdr_loaded");
    for (int i = 0; i < 10; i++) begin
      chk("bp_data_stable", tx_data, 8'hA2);
      chk("bp_no_ack", req_ack, 0);
      @(negedge clk);
    end
    step();
    tx_ack = 1'b1;
    @(negedge clk);
    chk("bp_same_edge_load", req_ack, 4'b0100);
    step();
    req_data[23:16] = 8'h22;
    req_last = 4'b0100;
    @(negedge clk);
    chk("bp_second_ack", req_ack, 4'b0100);
    step();
    req_rdy = '0;
    req_last = '0;
    wait_idle("bp_idle");

    // Timeout after one byte without last
    step();
    req_rdy = 4'b0010;
    req_data[15:8] = 8'h5C;
    tx_ack = 1'b1;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'h5C);
    wait_ack(1, "to_first_ack");
    step();
    req_rdy = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("to_pulse", terr, (c == 9));
      if (c == 9) chk("to_grant_held", grant, 4'b0010);
      if (c == 10) chk("to_grant_clear", grant, 0);
    end
    chk("to_idle", busy, 0);
    step();
    req_rdy = 4'b0010;
    req_data[15:8] = 8'h77;
    req_last = 4'b0010;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'h77);
    wait_ack(1, "to_rearb_ack");
    step();
    req_rdy = '0;
    req_last = '0;
    wait_idle("to_rearb_idle");

    // Asynchronous reset with a byte in flight
    step();
    req_rdy = 4'b1000;
    req_data[31:24] = 8'h3C;
    tx_ack = 1'b0;
    wait_tx_rdy("ar_pre_reset_hold");
    rst = 1'b0;
    #1;
    chk("ar_tx_rdy", tx_rdy, 0);
    chk("ar_grant", grant, 0);
    chk("ar_busy", busy, 0);
    chk("ar_tx_data", tx_data, 0);
    step();
    step();
    req_last = 4'b1000;
    tx_ack = 1'b1;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h3C);
    rst = 1'b1;
    wait_ack(3, "ar_fresh_ack");
    step();
    req_rdy = '0;
    req_last = '0;
    wait_idle("ar_idle");
    repeat (3) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
